// File: rtl/mips_pkg.sv
// Shared EXE-stage definitions: mudi op encoding, mul/div FSM states,
// divider iteration count and the op priority decoder.
package mips_pkg;

    localparam logic [3:0] MUDI_MULT  = 4'b0001;
    localparam logic [3:0] MUDI_MULTU = 4'b0010;
    localparam logic [3:0] MUDI_DIV   = 4'b0100;
    localparam logic [3:0] MUDI_DIVU  = 4'b1000;

    localparam int DIV_ITER = 32;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        FIX,
        DONE
    } muldiv_state_t;

    // Malformed multi-bit ops resolve with bit 0 highest priority.
    function automatic logic [3:0] mudi_prio(input logic [3:0] op);
        logic [3:0] r;
        r = 4'b0000;
        priority case (1'b1)
            op[0]:   r = MUDI_MULT;
            op[1]:   r = MUDI_MULTU;
            op[2]:   r = MUDI_DIV;
            op[3]:   r = MUDI_DIVU;
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/muldiv_sequencer_div_iter.sv
// Restoring radix-2 divider datapath: one quotient bit per step on
// unsigned magnitudes; sequencing is owned by muldiv_sequencer.
module div_iter
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        clear,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        done_cnt
);

    logic [31:0] dsr;
    logic [4:0]  cnt;
    logic [32:0] shifted;
    logic [32:0] diff;

    // quotient starts out holding the dividend and is shifted out MSB first
    assign shifted  = {remainder, quotient[31]};
    assign diff     = shifted - {1'b0, dsr};
    assign done_cnt = (cnt == 5'(DIV_ITER - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            quotient  <= '0;
            remainder <= '0;
            dsr       <= '0;
            cnt       <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load) begin
            quotient  <= dividend;
            remainder <= '0;
            dsr       <= divisor;
            cnt       <= '0;
        end else if (step) begin
            if (!diff[32]) begin
                remainder <= diff[31:0];
                quotient  <= {quotient[30:0], 1'b1};
            end else begin
                remainder <= shifted[31:0];
                quotient  <= {quotient[30:0], 1'b0};
            end
            cnt <= cnt + 5'd1;
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// EXE-stage multiply/divide sequencer with one-cycle HI/LO write strobe.
// Optional MULDIV_EARLY_OUT_EN: divides with |divisor| > |dividend| skip iteration.
module muldiv_sequencer
    import mips_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        cancel,
    output logic        busy,
    output logic        resp_valid,
    output logic [1:0]  hl_we,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata
);

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY_OUT = 1'b1;
`else
    localparam bit EARLY_OUT = 1'b0;
`endif

    muldiv_state_t state;

    logic [1:0]  cnt;
    logic [3:0]  op_sel;
    logic [3:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] mag1;
    logic [31:0] mag2;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] hi_res;
    logic [31:0] lo_res;
    logic [63:0] prod;
    logic        sgn;
    logic        s1;
    logic        s2;
    logic        q_neg;
    logic        r_neg;
    logic        dz;
    logic        early;
    logic        accept;
    logic        is_mul;
    logic        div_done;
    logic        div_step;

    logic signed [32:0] ma;
    logic signed [32:0] mb;
    logic signed [65:0] full;

    assign op_sel    = mudi_prio(req_op);
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = req_valid && req_ready && !cancel && (req_op != 4'b0);

    assign sgn  = op_sel[0] | op_sel[2];
    assign s1   = sgn & src1[31];
    assign s2   = sgn & src2[31];
    assign mag1 = s1 ? -src1 : src1;
    assign mag2 = s2 ? -src2 : src2;

    assign is_mul = op_q[0] | op_q[1];
    assign ma     = {op_q[0] & a_q[31], a_q};
    assign mb     = {op_q[0] & b_q[31], b_q};
    assign full   = ma * mb;

    assign div_step = (state == DIV) && !early && !cancel;

    div_iter u_div (
        .clk       (clk),
        .reset     (reset),
        .load      (accept),
        .clear     (cancel),
        .step      (div_step),
        .dividend  (mag1),
        .divisor   (mag2),
        .quotient  (quo),
        .remainder (rem),
        .done_cnt  (div_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            q_neg      <= 1'b0;
            r_neg      <= 1'b0;
            dz         <= 1'b0;
            early      <= 1'b0;
            prod       <= '0;
            hi_res     <= '0;
            lo_res     <= '0;
            resp_valid <= 1'b0;
            hl_we      <= 2'b00;
            hi_wdata   <= '0;
            lo_wdata   <= '0;
        end else begin
            resp_valid <= 1'b0;
            hl_we      <= 2'b00;
            if (cancel) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                unique case (state)
                    IDLE: if (accept) begin
                        op_q  <= op_sel;
                        a_q   <= src1;
                        b_q   <= src2;
                        q_neg <= s1 ^ s2;
                        r_neg <= s1;
                        dz    <= (src2 == 32'd0);
                        early <= EARLY_OUT && (mag2 != 32'd0) && (mag2 > mag1);
                        cnt   <= '0;
                        state <= (op_sel[1:0] != 2'b00) ? MUL : DIV;
                    end
                    MUL: begin
                        if (cnt == 2'd0) prod <= full[63:0];
                        if (cnt == 2'(MUL_LAT - 1)) begin
                            cnt   <= '0;
                            state <= DONE;
                        end else begin
                            cnt <= cnt + 2'd1;
                        end
                    end
                    DIV: if (early || div_done) state <= FIX;
                    FIX: begin
                        // a zero divisor leaves |dividend| in rem, r_neg restores its sign
                        hi_res <= early ? quo : (r_neg ? -rem : rem);
                        lo_res <= dz ? '1 : early ? '0 : (q_neg ? -quo : quo);
                        state  <= DONE;
                    end
                    DONE: begin
                        resp_valid <= 1'b1;
                        hl_we      <= 2'b11;
                        hi_wdata   <= is_mul ? prod[63:32] : hi_res;
                        lo_wdata   <= is_mul ? prod[31:0] : lo_res;
                        state      <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed vectors push expected
// HI/LO plus response cycle; a negedge monitor pops and compares.
module tb_muldiv_sequencer;
    import mips_pkg::*;

    localparam int MUL_LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = 4'b0;
    logic [31:0] src1 = '0;
    logic [31:0] src2 = '0;
    logic        cancel = 1'b0;
    logic        busy;
    logic        resp_valid;
    logic [1:0]  hl_we;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;

    muldiv_sequencer #(.MUL_LAT(MUL_LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .src1       (src1),
        .src2       (src2),
        .cancel     (cancel),
        .busy       (busy),
        .resp_valid (resp_valid),
        .hl_we      (hl_we),
        .hi_wdata   (hi_wdata),
        .lo_wdata   (lo_wdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          at;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_resp: got hi=%h lo=%h want no response (cyc %0d)",
                             hi_wdata, lo_wdata, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("hi", {32'd0, hi_wdata}, {32'd0, e.hi});
                    chk("lo", {32'd0, lo_wdata}, {32'd0, e.lo});
                    chk("hl_we_on", {62'd0, hl_we}, 64'd3);
                    chk("resp_cycle", 64'(cyc), 64'(e.at));
                end
            end else begin
                chk("hl_we_off", {62'd0, hl_we}, 64'd0);
            end
        end
    end

    function automatic int div_lat(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        logic [31:0] ma;
        logic [31:0] mb;
        ma = (op[2] && a[31]) ? -a : a;
        mb = (op[2] && b[31]) ? -b : b;
`ifdef MULDIV_EARLY_OUT_EN
        if (mb != 32'd0 && mb > ma) return 3;
`endif
        if (ma == mb) return 34;
        return 34;
    endfunction

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] hi, input logic [31:0] lo, input int lat);
        int n;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_op    = op;
        src1      = a;
        src2      = b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 4'b0;
        sb.push_back('{hi, lo, cyc + lat});
        chk("busy_after_accept", {63'd0, busy}, 64'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hi, input logic [31:0] lo);
        int lat;
        lat = (op[0] | op[1]) ? MUL_LAT + 1 : div_lat(op, a, b);
        issue(op, a, b, hi, lo, lat);
        drain();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cyc %0d)", cyc);
        $fatal(1);
    end

    int acc;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_resp", {63'd0, resp_valid}, 64'd0);
        chk("rst_hl_we", {62'd0, hl_we}, 64'd0);
        chk("rst_hi", {32'd0, hi_wdata}, 64'd0);
        chk("rst_lo", {32'd0, lo_wdata}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run(MUDI_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA);
        run(MUDI_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run(MUDI_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001);
        run(4'b0110,    32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE);
        run(MUDI_DIVU,  32'd100,      32'd7,        32'd2,        32'd14);
        run(MUDI_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        run(MUDI_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD);
        run(MUDI_DIV,   32'hFFFFFFEC, 32'd6,        32'hFFFFFFFE, 32'hFFFFFFFD);
        run(MUDI_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        run(MUDI_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF);
        run(MUDI_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF);
        run(MUDI_DIVU,  32'd3,        32'd10,       32'd3,        32'd0);
        run(MUDI_DIV,   32'd7,        32'hFFFFFFF6, 32'd7,        32'd0);
        run(MUDI_DIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF);
        run(4'b1100,    32'd100,      32'd7,        32'd2,        32'd14);

        // DIV cancelled at E10, then MULTU accepted right away
        req_valid = 1'b1;
        req_op    = MUDI_DIVU;
        src1      = 32'd100;
        src2      = 32'd7;
        @(posedge clk);
        #1;
        acc       = cyc;
        req_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        chk("cancel_busy", {63'd0, busy}, 64'd0);
        chk("cancel_ready", {63'd0, req_ready}, 64'd1);
        issue(MUDI_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, MUL_LAT + 1);
        drain();
        repeat (30) @(negedge clk);

        // cancel during the DONE cycle suppresses the write
        req_valid = 1'b1;
        req_op    = MUDI_MULT;
        src1      = 32'd9;
        src2      = 32'd9;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (MUL_LAT) @(posedge clk);
        #1;
        chk("done_busy", {63'd0, busy}, 64'd1);
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        chk("done_cancel_busy", {63'd0, busy}, 64'd0);
        repeat (5) @(negedge clk);

        // request held while busy is taken only once IDLE
        req_valid = 1'b1;
        req_op    = MUDI_DIVU;
        src1      = 32'd100;
        src2      = 32'd7;
        @(posedge clk);
        #1;
        acc    = cyc;
        req_op = MUDI_MULTU;
        src1   = 32'd2;
        src2   = 32'd3;
        sb.push_back('{32'd2, 32'd14, acc + 34});
        sb.push_back('{32'd0, 32'd6, acc + 35 + MUL_LAT + 1});
        repeat (20) @(posedge clk);
        #1;
        chk("held_busy", {63'd0, busy}, 64'd1);
        repeat (15) @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 4'b0;
        drain();

        // reset mid-operation behaves like cancel and clears HI/LO data
        issue(MUDI_MULT, 32'hFFFFFFFE, 32'd3, 32'd0, 32'd0, MUL_LAT + 1);
        void'(sb.pop_back());
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_ready", {63'd0, req_ready}, 64'd1);
        chk("midrst_hi", {32'd0, hi_wdata}, 64'd0);
        chk("midrst_lo", {32'd0, lo_wdata}, 64'd0);
        repeat (6) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
